// File: rtl/team_06_audio_pkg.sv
// Shared types and constants for the team_06 audio effects chain.
// Imported by the PWM output stage and its sample FIFO.
package team_06_audio_pkg;

    typedef logic [7:0] sample_t;

    localparam int unsigned PWM_PERIOD = 255;
    localparam sample_t     SAMPLE_MID = 8'd128;

    // A WIDTH-bit sample maps onto a frame of 2^WIDTH-1 cycles.
    // This lets the full-scale code hold the pin high for the whole frame.
    function automatic int unsigned pwm_period(input int unsigned width);
        return (32'd1 << width) - 32'd1;
    endfunction

endpackage

// File: rtl/team_06_sample_fifo.sv
// Synchronous sample FIFO with push, pop and flush; exposes occupancy, full and empty.
// DEPTH must be a power of two so the pointers wrap naturally.
module team_06_sample_fifo
    import team_06_audio_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     nrst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam logic [LW-1:0] FullLevel = DEPTH[LW-1:0];

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             do_push, do_pop;

    assign full  = (level_q == FullLevel);
    assign empty = (level_q == '0);
    assign level = level_q;
    assign rdata = mem_q[rd_ptr_q];

    // Full is judged on the registered level, so a same-cycle pop never frees a slot.
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

endmodule

// File: rtl/team_06_pwm_out.sv
// PWM output stage: buffers samples and renders each as one 2^WIDTH-1 cycle PWM frame.
// Define TEAM_06_PWM_UNDERRUN_CNT_EN to add the saturating underrun_cnt port.
module team_06_pwm_out
    import team_06_audio_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   nrst,
    input  logic                   en,
    input  logic [WIDTH-1:0]       sample_in,
    input  logic                   sample_valid,
    output logic                   sample_ready,
    output logic [$clog2(DEPTH):0] level,
    output logic                   pwm_out,
    output logic                   underrun
`ifdef TEAM_06_PWM_UNDERRUN_CNT_EN
    ,
    output logic [7:0]             underrun_cnt
`endif
);

    localparam int unsigned    Period  = pwm_period(WIDTH);
    localparam logic [WIDTH-1:0] CntLast = WIDTH'(Period - 1);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] duty_q, duty_d;
    logic             pwm_q, pwm_d;
    logic             underrun_q, underrun_d;

    logic             frame_end;
    logic             fifo_push, fifo_pop;
    logic             fifo_full, fifo_empty;
    logic [WIDTH-1:0] fifo_head;

    assign sample_ready = en && !fifo_full;
    assign fifo_push    = sample_valid && sample_ready;
    assign frame_end    = en && (cnt_q == CntLast);
    // A sample pushed on the boundary cycle is not visible yet; no bypass to duty.
    assign fifo_pop     = frame_end && !fifo_empty;

    team_06_sample_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_fifo (
        .clk   (clk),
        .nrst  (nrst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .flush (!en),
        .wdata (sample_in),
        .rdata (fifo_head),
        .level (level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        cnt_d      = '0;
        duty_d     = '0;
        pwm_d      = 1'b0;
        underrun_d = 1'b0;
        if (en) begin
            cnt_d      = frame_end ? '0 : cnt_q + WIDTH'(1);
            duty_d     = fifo_pop ? fifo_head : duty_q;
            pwm_d      = (cnt_q < duty_q);
            underrun_d = frame_end && fifo_empty;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt_q      <= '0;
            duty_q     <= '0;
            pwm_q      <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            duty_q     <= duty_d;
            pwm_q      <= pwm_d;
            underrun_q <= underrun_d;
        end
    end

    assign pwm_out  = pwm_q;
    assign underrun = underrun_q;

`ifdef TEAM_06_PWM_UNDERRUN_CNT_EN
    // Cleared by reset only; dropping en leaves the history intact.
    logic [7:0] ucnt_q, ucnt_d;

    always_comb begin
        ucnt_d = ucnt_q;
        if (underrun_q && (ucnt_q != 8'hFF)) begin
            ucnt_d = ucnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            ucnt_q <= 8'd0;
        end else begin
            ucnt_q <= ucnt_d;
        end
    end

    assign underrun_cnt = ucnt_q;
`endif

endmodule

// File: tb/tb_team_06_pwm_out.sv
// Directed self-checking bench for team_06_pwm_out (default DEPTH=4, WIDTH=8).
module tb_team_06_pwm_out;

    logic       clk = 1'b0;
    logic       nrst;
    logic       en;
    logic [7:0] sample_in;
    logic       sample_valid;
    logic       sample_ready;
    logic [2:0] level;
    logic       pwm_out;
    logic       underrun;
`ifdef TEAM_06_PWM_UNDERRUN_CNT_EN
    logic [7:0] underrun_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int phase = 0;

    always #5 clk = ~clk;

    team_06_pwm_out #(
        .DEPTH (4),
        .WIDTH (8)
    ) dut (
        .clk          (clk),
        .nrst         (nrst),
        .en           (en),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .level        (level),
        .pwm_out      (pwm_out),
        .underrun     (underrun)
`ifdef TEAM_06_PWM_UNDERRUN_CNT_EN
        ,
        .underrun_cnt (underrun_cnt)
`endif
    );

    // Bench-side frame position: mirrors where cnt must be after each edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (!nrst || !en) phase = 0;
        else phase = (phase == 254) ? 0 : phase + 1;
    endtask

    task automatic run_frame(output int highs, output int unders, output logic first);
        highs  = 0;
        unders = 0;
        first  = 1'b0;
        for (int k = 0; k < 255; k++) begin
            tick();
            if (k == 0) first = pwm_out;
            highs  += int'(pwm_out);
            unders += int'(underrun);
        end
    endtask

    task automatic to_phase(input int target);
        int n = 0;
        while (phase != target && n < 300) begin
            tick();
            n++;
        end
        n_cmp++;
        if (phase != target) begin
            n_bad++;
            $display("FAIL to_phase: got phase %0d want %0d", phase, target);
        end
    endtask

    task automatic push(input logic [7:0] v, input logic exp_ready);
        sample_in    = v;
        sample_valid = 1'b1;
        #1;
        n_cmp++;
        if (sample_ready !== exp_ready) begin
            n_bad++;
            $display("FAIL push_ready(%0d): got %0b want %0b", v, sample_ready, exp_ready);
        end
        tick();
        sample_valid = 1'b0;
    endtask

    task automatic test_reset();
        int pulses = 0, first_at = 0, second_at = 0, highs = 0;
        nrst = 1'b0; en = 1'b0; sample_valid = 1'b0; sample_in = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (pwm_out !== 1'b0) begin n_bad++; $display("FAIL rst_pwm: got %0b want 0", pwm_out); end
        n_cmp++; if (underrun !== 1'b0) begin n_bad++; $display("FAIL rst_underrun: got %0b want 0", underrun); end
        n_cmp++; if (level !== 3'd0) begin n_bad++; $display("FAIL rst_level: got %0d want 0", level); end
        n_cmp++; if (sample_ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready: got %0b want 0", sample_ready); end
        nrst = 1'b1; en = 1'b1; phase = 0;
        #1;
        n_cmp++; if (sample_ready !== 1'b1) begin n_bad++; $display("FAIL en_ready: got %0b want 1", sample_ready); end
        for (int i = 1; i <= 510; i++) begin
            tick();
            highs += int'(pwm_out);
            if (underrun === 1'b1) begin
                pulses++;
                if (pulses == 1) first_at = i;
                if (pulses == 2) second_at = i;
            end
        end
        n_cmp++; if (pulses != 2) begin n_bad++; $display("FAIL starve_pulses: got %0d want 2", pulses); end
        n_cmp++; if (first_at != 255) begin n_bad++; $display("FAIL starve_first: got %0d want 255", first_at); end
        n_cmp++; if (second_at != 510) begin n_bad++; $display("FAIL starve_second: got %0d want 510", second_at); end
        n_cmp++; if (highs != 0) begin n_bad++; $display("FAIL starve_pwm: got %0d want 0", highs); end
        n_cmp++; if (level !== 3'd0) begin n_bad++; $display("FAIL starve_level: got %0d want 0", level); end
    endtask

    task automatic test_duty_mid();
        int h, u; logic f;
        push(8'd128, 1'b1);
        push(8'd128, 1'b1);
        n_cmp++; if (level !== 3'd2) begin n_bad++; $display("FAIL mid_level2: got %0d want 2", level); end
        to_phase(0);
        n_cmp++; if (level !== 3'd1) begin n_bad++; $display("FAIL mid_level1: got %0d want 1", level); end
        n_cmp++; if (pwm_out !== 1'b0) begin n_bad++; $display("FAIL mid_latency0: got %0b want 0", pwm_out); end
        run_frame(h, u, f);
        n_cmp++; if (f !== 1'b1) begin n_bad++; $display("FAIL mid_latency1: got %0b want 1", f); end
        n_cmp++; if (h != 128) begin n_bad++; $display("FAIL mid_frame1_high: got %0d want 128", h); end
        n_cmp++; if (u != 0) begin n_bad++; $display("FAIL mid_frame1_under: got %0d want 0", u); end
        run_frame(h, u, f);
        n_cmp++; if (h != 128) begin n_bad++; $display("FAIL mid_frame2_high: got %0d want 128", h); end
        n_cmp++; if (u != 1) begin n_bad++; $display("FAIL mid_frame2_under: got %0d want 1", u); end
    endtask

    task automatic test_zero_full();
        int h, u; logic f;
        push(8'd0, 1'b1);
        push(8'd255, 1'b1);
        to_phase(0);
        run_frame(h, u, f);
        n_cmp++; if (h != 0) begin n_bad++; $display("FAIL zero_high: got %0d want 0", h); end
        n_cmp++; if (u != 0) begin n_bad++; $display("FAIL zero_under: got %0d want 0", u); end
        run_frame(h, u, f);
        n_cmp++; if (h != 255) begin n_bad++; $display("FAIL full_high: got %0d want 255", h); end
        n_cmp++; if (u != 1) begin n_bad++; $display("FAIL full_under: got %0d want 1", u); end
        run_frame(h, u, f);
        n_cmp++; if (h != 255) begin n_bad++; $display("FAIL full_hold_high: got %0d want 255", h); end
    endtask

    task automatic test_fifo_full();
        logic [7:0] vals [5];
        int h = 0;
        vals[0] = 8'd10; vals[1] = 8'd20; vals[2] = 8'd30; vals[3] = 8'd40; vals[4] = 8'd50;
        sample_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            sample_in = vals[k];
            #1;
            n_cmp++;
            if (sample_ready !== (k < 4)) begin
                n_bad++;
                $display("FAIL fill_ready[%0d]: got %0b want %0b", k, sample_ready, (k < 4));
            end
            tick();
        end
        sample_valid = 1'b0;
        n_cmp++; if (level !== 3'd4) begin n_bad++; $display("FAIL fill_level: got %0d want 4", level); end
        to_phase(254);
        sample_in = 8'd99; sample_valid = 1'b1;
        #1;
        n_cmp++; if (sample_ready !== 1'b0) begin n_bad++; $display("FAIL full_pop_ready: got %0b want 0", sample_ready); end
        tick();
        sample_valid = 1'b0;
        n_cmp++; if (level !== 3'd3) begin n_bad++; $display("FAIL pop_level: got %0d want 3", level); end
        for (int k = 0; k < 100; k++) begin
            tick();
            h += int'(pwm_out);
        end
        n_cmp++; if (h != 10) begin n_bad++; $display("FAIL head_duty: got %0d want 10", h); end
    endtask

    task automatic test_enable();
        int h = 0, u = 0; logic f;
        en = 1'b0;
        #1;
        n_cmp++; if (sample_ready !== 1'b0) begin n_bad++; $display("FAIL dis_ready: got %0b want 0", sample_ready); end
        tick();
        n_cmp++; if (level !== 3'd0) begin n_bad++; $display("FAIL dis_level: got %0d want 0", level); end
        n_cmp++; if (pwm_out !== 1'b0) begin n_bad++; $display("FAIL dis_pwm: got %0b want 0", pwm_out); end
        for (int k = 0; k < 300; k++) begin
            tick();
            h += int'(pwm_out);
            u += int'(underrun);
        end
        n_cmp++; if (h != 0 || u != 0) begin n_bad++; $display("FAIL dis_quiet: got %0d/%0d want 0/0", h, u); end
        en = 1'b1;
        #1;
        push(8'd64, 1'b1);
        to_phase(0);
        n_cmp++; if (level !== 3'd0) begin n_bad++; $display("FAIL reen_level: got %0d want 0", level); end
        run_frame(h, u, f);
        n_cmp++; if (h != 64) begin n_bad++; $display("FAIL reen_high: got %0d want 64", h); end
        n_cmp++; if (f !== 1'b1) begin n_bad++; $display("FAIL reen_first: got %0b want 1", f); end
        n_cmp++; if (u != 1) begin n_bad++; $display("FAIL reen_under: got %0d want 1", u); end
    endtask

    task automatic test_back_to_back();
        int h, u; logic f;
        push(8'd200, 1'b1);
        to_phase(254);
        push(8'd50, 1'b1);
        n_cmp++; if (level !== 3'd1) begin n_bad++; $display("FAIL pushpop_level: got %0d want 1", level); end
        n_cmp++; if (underrun !== 1'b0) begin n_bad++; $display("FAIL pushpop_under: got %0b want 0", underrun); end
        run_frame(h, u, f);
        n_cmp++; if (h != 200) begin n_bad++; $display("FAIL b2b_a_high: got %0d want 200", h); end
        run_frame(h, u, f);
        n_cmp++; if (h != 50 || u != 1) begin n_bad++; $display("FAIL b2b_b: got %0d/%0d want 50/1", h, u); end
        to_phase(254);
        push(8'd100, 1'b1);
        n_cmp++; if (underrun !== 1'b1) begin n_bad++; $display("FAIL nobypass_under: got %0b want 1", underrun); end
        n_cmp++; if (level !== 3'd1) begin n_bad++; $display("FAIL nobypass_level: got %0d want 1", level); end
        run_frame(h, u, f);
        n_cmp++; if (h != 50 || u != 0) begin n_bad++; $display("FAIL nobypass_hold: got %0d/%0d want 50/0", h, u); end
        run_frame(h, u, f);
        n_cmp++; if (h != 100) begin n_bad++; $display("FAIL nobypass_c: got %0d want 100", h); end
    endtask

    task automatic test_async_reset();
        int h, u; logic f;
        push(8'd30, 1'b1);
        repeat (9) tick();
        n_cmp++; if (pwm_out !== 1'b1) begin n_bad++; $display("FAIL pre_rst_pwm: got %0b want 1", pwm_out); end
        #2;
        nrst = 1'b0;
        #1;
        n_cmp++; if (pwm_out !== 1'b0) begin n_bad++; $display("FAIL async_pwm: got %0b want 0", pwm_out); end
        n_cmp++; if (level !== 3'd0) begin n_bad++; $display("FAIL async_level: got %0d want 0", level); end
        tick();
        nrst = 1'b1;
        phase = 0;
        run_frame(h, u, f);
        n_cmp++; if (h != 0 || u != 1) begin n_bad++; $display("FAIL post_rst_frame: got %0d/%0d want 0/1", h, u); end
    endtask

`ifdef TEAM_06_PWM_UNDERRUN_CNT_EN
    task automatic test_underrun_cnt();
        int h, u; logic f;
        nrst = 1'b0;
        tick();
        nrst = 1'b1;
        phase = 0;
        n_cmp++; if (underrun_cnt !== 8'd0) begin n_bad++; $display("FAIL ucnt_rst: got %0d want 0", underrun_cnt); end
        run_frame(h, u, f);
        tick();
        n_cmp++; if (underrun_cnt !== 8'd1) begin n_bad++; $display("FAIL ucnt_one: got %0d want 1", underrun_cnt); end
        for (int k = 0; k < 299; k++) run_frame(h, u, f);
        tick();
        n_cmp++; if (underrun_cnt !== 8'd255) begin n_bad++; $display("FAIL ucnt_sat: got %0d want 255", underrun_cnt); end
        en = 1'b0;
        repeat (5) tick();
        en = 1'b1;
        tick();
        n_cmp++; if (underrun_cnt !== 8'd255) begin n_bad++; $display("FAIL ucnt_en: got %0d want 255", underrun_cnt); end
        nrst = 1'b0;
        #1;
        n_cmp++; if (underrun_cnt !== 8'd0) begin n_bad++; $display("FAIL ucnt_clear: got %0d want 0", underrun_cnt); end
        tick();
        nrst = 1'b1;
        phase = 0;
    endtask
`endif

    initial begin
        test_reset();
        test_duty_mid();
        test_zero_full();
        test_fifo_full();
        test_enable();
        test_back_to_back();
        test_async_reset();
`ifdef TEAM_06_PWM_UNDERRUN_CNT_EN
        test_underrun_cnt();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/team_06_pwm_out.md
# team_06_pwm_out

Downstream output stage of the team_06 audio effects chain: accepts 8-bit unsigned processed samples, buffers them in a small FIFO, and renders each one as one period of a 255-cycle PWM waveform on a single pin driving the board's RC low-pass filter. It decouples the effect pipeline's sample strobe from the fixed PWM frame rate and reports underruns when the chain starves the output.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `WIDTH`, 8: sample width; PWM period is 2^WIDTH−1 cycles.

Ports:
- `clk`  in  1  system clock.
- `nrst`  in  1  reset. One clock; reset is asynchronous and active-low.
- `en`  in  1  output enable; low = silence and flush.
- `sample_in`  in  WIDTH  unsigned sample; 128 = midscale.
- `sample_valid`  in  1  `sample_in` is valid this cycle.
- `sample_ready`  out  1  FIFO can accept; combinational: `en && level < DEPTH`.
- `level`  out  $clog2(DEPTH)+1  current FIFO occupancy.
- `pwm_out`  out  1  registered PWM output.
- `underrun`  out  1  one-cycle pulse: frame boundary with an empty FIFO.
- `underrun_cnt`  out  8  saturating underrun count (only with `TEAM_06_PWM_UNDERRUN_CNT_EN`).

## Operation
- Push: `sample_valid && sample_ready` at a rising edge writes `sample_in` to the tail. Valid while not ready is dropped; no stall.
- Frame counter `cnt` runs 0..254, wraps to 0. Frame boundary = cycle with `cnt == 254 && en`.
- At a frame boundary: FIFO non-empty → pop head into `duty`; empty → `duty` holds, `underrun` pulses next cycle.
- `pwm_out <= en && (cnt < duty)`. duty 0 → constantly low; duty 255 → constantly high; duty 128 → 128 high of 255.
- Simultaneous push and pop: both occur; `level` unchanged. Push into an empty FIFO on a boundary cycle does not satisfy that pop (no bypass); underrun still fires.
- `sample_ready` uses the registered `level`; a pop in the same cycle does not make a full FIFO ready.
- `en` low (synchronous): FIFO flushed (`level` 0), `cnt` 0, `duty` 0, `pwm_out` 0, no underrun pulses. Rising `en` starts a frame at `cnt` 0 with duty 0; first sample is popped at the first boundary.

## Timing
- Reset values: `cnt` 0, `duty` 0, `level` 0, `pwm_out` 0, `underrun` 0, `underrun_cnt` 0; `sample_ready` 0 while `en` low.
- Push-to-output: a sample pushed into an empty FIFO appears on `pwm_out` from the cycle after the next boundary's `cnt`-0 cycle (registered compare).
- Frame length exactly 255 cycles; no idle cycle at wrap.
- Reset asserted mid-frame clears everything immediately; no partial frame completes.

## Configuration
- `TEAM_06_PWM_UNDERRUN_CNT_EN` defined: `underrun_cnt` port exists, increments on each `underrun` pulse, saturates at 255, clears on reset only (not on `en` low).
- Undefined: port and counter absent; `underrun` pulse unchanged.

## Structure
- `team_06_audio_pkg`: `sample_t` (logic [7:0]), `PWM_PERIOD` = 255, `SAMPLE_MID` = 128.
- Sub-module `team_06_sample_fifo`: synchronous FIFO with push/pop/flush, `level`, full/empty; top holds counter, duty register, compare, and underrun logic.

## Test plan
- Reset with `en`=1, no pushes: `pwm_out` 0, `underrun` pulses once per 255 cycles, `level` 0.
- Push 128, steady stream: each frame `pwm_out` high exactly 128 of 255 cycles.
- Push 0 then 255: one frame all low, next frame all high, no glitch at wrap.
- Push 5 samples with `DEPTH`=4 and no pop: first 4 accepted, `sample_ready` drops at `level` 4, 5th dropped; next boundary pops, `level` 3.
- Drop `en` with `level` 3 mid-frame: next cycle `level` 0, `pwm_out` 0, `cnt` 0; re-enable, push 64 → 64-high frame after first boundary.
- With macro: 300 boundaries starved → `underrun_cnt` 255; `en` toggled → still 255; `nrst` → 0.
